seg_scan_capture: RTL and testbench
===================================

// Module: seg_scan_capture
// PURPOSE
//  Receive side of the multiplexed 3-digit 7-segment display bus driven by the display driver.
//  Samples seg/an and waits for each anode dwell to settle. Decodes the lit pattern back
//  into a 4-bit hex digit and holds the three recovered digits in registers.
//  Used as an on-chip loopback monitor / self-check of the display path; flags illegal
//  bus states and stale digits.
// PARAMETERS
//  STABLE_CYCLES  4      consecutive identical samples required before a capture (>=2)
//  TIMEOUT        65536  clocks without a capture before a digit's valid bit is cleared
//  SEG_ACTIVE_LOW 0      1: seg bits are lit when 0 (inverted before decode)
// PORTS
//  clocksource  in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  seg          in   7  segment bus, seg[0]=a .. seg[6]=g
//  an           in   3  anode selects, active-low, an[i]=0 selects digit i
//  x0           out  4  last digit captured while an=3'b110
//  x1           out  4  last digit captured while an=3'b101
//  x2           out  4  last digit captured while an=3'b011
//  digit_valid  out  3  bit i set on capture into xi, cleared by timeout or reset
//  frame_done   out  1  1-cycle pulse when all three digits captured since last pulse
//  seg_err      out  1  1-cycle pulse: stable pattern under valid anode is not a hex glyph
//  an_err       out  1  1-cycle pulse: stable anode value has more than one bit low
// BEHAVIOUR
//  - Reset, synchronous: x0..x2=0, digit_valid=0, frame_done=0, seg_err=0, an_err=0.
//    Also clears the sample register, the stability counter, the frame mask and the timeout counters.
//  - Reset has priority over all other events. Asserted mid-dwell, the dwell restarts from zero.
//  - Each clock, {an,seg} is stored in a sample register. stab_cnt is compared against it:
//    input == sample -> stab_cnt saturating increment; otherwise stab_cnt <= 0.
//  - FSM states:
//    WAIT: stab_cnt < STABLE_CYCLES-1.
//    EVAL: first cycle at which the input has matched on STABLE_CYCLES consecutive edges.
//    HELD: pattern unchanged after EVAL.
//    Transitions: WAIT->EVAL when the count is reached. EVAL->HELD unconditionally.
//    Any input change returns the FSM to WAIT.
//  - Only EVAL acts, exactly once per dwell. Outputs are registered, so they are visible
//    on the clock after the STABLE_CYCLES-th matching sample.
//  - EVAL with an==3'b111 (blank): no action, no error.
//  - EVAL with exactly one an bit low:
//    - Decode seg (after optional inversion). The glyph table is gfedcba:
//      0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//    - Match: xi <= digit, digit_valid[i] <= 1, frame mask bit i <= 1, timeout_cnt[i] <= 0.
//    - No match: seg_err pulse. xi, digit_valid and the mask are unchanged.
//  - EVAL with two or more an bits low: an_err pulse, nothing else changes.
//  - Frame: when the mask (including the capture being made this cycle) becomes 3'b111,
//    frame_done pulses on that same register update and the mask clears to 0.
//    Recapturing a digit already in the mask is allowed and does not pulse frame_done.
//  - Timeout: each timeout_cnt[i] increments every clock and saturates at TIMEOUT-1.
//    On reaching TIMEOUT-1, digit_valid[i] <= 0; xi keeps its last value.
//    A capture in the same cycle wins: the bit stays 1 and the counter resets.
//  - Widths: stab_cnt is $clog2(STABLE_CYCLES+1) bits; timeout_cnt is $clog2(TIMEOUT) bits.
//  - Input timing: seg/an are assumed synchronous to clocksource; no metastability stages.
// TESTING
//  1 reset high 2 clocks with random bus -> all outputs 0; release with an=111 -> no pulses.
//  2 an=110, seg=4F for 4 clocks -> x0=3, digit_valid=001 after 4th edge.
//    Same pattern for only 3 clocks, then change -> no update.
//  3 scan an=110/101/011 with 06/5B/4F, 8 clocks each ->
//    x0=1, x1=2, x2=3, valid=111, one frame_done pulse on the x2 capture.
//  4 an=101, seg=00 held 8 clocks -> single seg_err pulse; x1 and valid[1] unchanged.
//    Then an=100, seg=06 -> single an_err pulse.
//  5 TIMEOUT=16: capture x2, then refresh only digits 0/1 -> valid[2] drops 15 clocks
//    after the x2 capture; valid[1:0] stay 1.
//  6 reset asserted on 3rd stable cycle of an=110, seg=7F, then released with pattern held ->
//    x0=8 only after 4 further stable clocks.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive-side monitor for a multiplexed 3-digit 7-segment bus.
// It waits until the segment and anode bus pattern has been stable for a set number
// of clocks (one dwell), decodes the lit glyph into a hex digit, and holds the three
// recovered digits. It also flags illegal bus states and digits that have gone stale.
// Ports:
//   clocksource  in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   seg[6:0]     in   segment bus, seg[0]=a .. seg[6]=g
//   an[2:0]      in   active-low anode selects, an[i]=0 selects digit i
//   x0/x1/x2     out  last digit captured for anode 0/1/2
//   digit_valid  out  per-digit valid, cleared on timeout
//   frame_done   out  pulse when all three digits have been captured since the last pulse
//   seg_err      out  pulse: stable pattern under a single anode is not a hex glyph
//   an_err       out  pulse: stable anode value has more than one bit low
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT        = 65536,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clocksource,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [2:0] an,
  output logic [3:0] x0,
  output logic [3:0] x1,
  output logic [3:0] x2,
  output logic [2:0] digit_valid,
  output logic       frame_done,
  output logic       seg_err,
  output logic       an_err
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_EVAL = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_EVAL, ST_HELD} state_t;

  state_t        r_state;
  logic [9:0]    r_sample;
  logic [SW-1:0] r_stab_cnt;
  logic [2:0]    r_mask;
  logic [TW-1:0] r_to_cnt [3];
  logic [3:0]    r_x [3];
  logic [2:0]    r_valid;
  logic          r_frame;
  logic          r_seg_err;
  logic          r_an_err;

  state_t        w_state_nxt;
  logic [9:0]    w_bus;
  logic          w_match;
  logic [SW-1:0] w_stab_nxt;
  logic [6:0]    w_lit;
  logic [3:0]    w_digit;
  logic          w_glyph_ok;
  logic [2:0]    w_an_sel;
  logic          w_an_one;
  logic          w_an_multi;
  logic [2:0]    w_cap;
  logic          w_seg_err;
  logic          w_an_err;
  logic [2:0]    w_mask_new;
  logic [TW-1:0] w_to_nxt [3];

  // Stability tracking against last clock's sample
  assign w_bus      = {an, seg};
  assign w_match    = (w_bus == r_sample);
  assign w_stab_nxt = !w_match ? '0 :
                      (r_stab_cnt == STAB_MAX) ? r_stab_cnt : r_stab_cnt + SW'(1);

  // Anode classification: one-hot-low selects a digit, two or more low is illegal
  assign w_an_sel   = ~an;
  assign w_an_one   = (w_an_sel == 3'b001) || (w_an_sel == 3'b010) || (w_an_sel == 3'b100);
  assign w_an_multi = (w_an_sel == 3'b011) || (w_an_sel == 3'b101) ||
                      (w_an_sel == 3'b110) || (w_an_sel == 3'b111);

  // Glyph decode (gfedcba)
  always_comb begin
    w_lit      = SEG_ACTIVE_LOW ? ~seg : seg;
    w_glyph_ok = 1'b1;
    w_digit    = 4'h0;
    case (w_lit)
      7'h3F: w_digit = 4'h0;
      7'h06: w_digit = 4'h1;
      7'h5B: w_digit = 4'h2;
      7'h4F: w_digit = 4'h3;
      7'h66: w_digit = 4'h4;
      7'h6D: w_digit = 4'h5;
      7'h7D: w_digit = 4'h6;
      7'h07: w_digit = 4'h7;
      7'h7F: w_digit = 4'h8;
      7'h6F: w_digit = 4'h9;
      7'h77: w_digit = 4'hA;
      7'h7C: w_digit = 4'hB;
      7'h39: w_digit = 4'hC;
      7'h5E: w_digit = 4'hD;
      7'h79: w_digit = 4'hE;
      7'h71: w_digit = 4'hF;
      default: w_glyph_ok = 1'b0;
    endcase
  end

  // FSM next state and the single per-dwell action, taken on the edge entering EVAL
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 3'b000;
    w_seg_err   = 1'b0;
    w_an_err    = 1'b0;
    if (!w_match) begin
      w_state_nxt = ST_WAIT;
    end else begin
      case (r_state)
        ST_WAIT: if (w_stab_nxt == STAB_EVAL) w_state_nxt = ST_EVAL;
        ST_EVAL: w_state_nxt = ST_HELD;
        default: w_state_nxt = ST_HELD;
      endcase
    end
    if (w_state_nxt == ST_EVAL) begin
      if (w_an_one) begin
        if (w_glyph_ok) w_cap = w_an_sel;
        else            w_seg_err = 1'b1;
      end else if (w_an_multi) begin
        w_an_err = 1'b1;
      end
    end
  end

  assign w_mask_new = r_mask | w_cap;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_to_nxt[i] = (r_to_cnt[i] == TO_MAX) ? r_to_cnt[i] : r_to_cnt[i] + TW'(1);
    end
  end

  always_ff @(posedge clocksource) begin
    if (reset) begin
      r_state    <= ST_WAIT;
      r_sample   <= '0;
      r_stab_cnt <= '0;
      r_mask     <= '0;
      r_valid    <= '0;
      r_frame    <= 1'b0;
      r_seg_err  <= 1'b0;
      r_an_err   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_to_cnt[i] <= '0;
        r_x[i]      <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_sample   <= w_bus;
      r_stab_cnt <= w_stab_nxt;
      r_seg_err  <= w_seg_err;
      r_an_err   <= w_an_err;
      // Frame completes on the capture that fills the mask; that capture also clears it
      if (w_mask_new == 3'b111) begin
        r_mask  <= 3'b000;
        r_frame <= 1'b1;
      end else begin
        r_mask  <= w_mask_new;
        r_frame <= 1'b0;
      end
      // A capture beats a timeout landing on the same clock
      for (int i = 0; i < 3; i++) begin
        if (w_cap[i]) begin
          r_x[i]      <= w_digit;
          r_valid[i]  <= 1'b1;
          r_to_cnt[i] <= '0;
        end else begin
          r_to_cnt[i] <= w_to_nxt[i];
          if (w_to_nxt[i] == TO_MAX) r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign x0          = r_x[0];
  assign x1          = r_x[1];
  assign x2          = r_x[2];
  assign digit_valid = r_valid;
  assign frame_done  = r_frame;
  assign seg_err     = r_seg_err;
  assign an_err      = r_an_err;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: dwell-level reference model feeding a scoreboard of
// expected output events, plus cycle-exact checks of capture latency, reset and timeout.
module tb_seg_scan_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] tb_seg = 7'h00;
  logic [2:0] tb_an = 3'b111;

  logic [3:0] x0, x1, x2;
  logic [2:0] valid;
  logic       frame, serr, aerr;
  logic [3:0] t_x0, t_x1, t_x2;
  logic [2:0] t_valid;
  logic       t_frame, t_serr, t_aerr;

  always #5 clk = ~clk;

  seg_scan_capture dut (
    .clocksource(clk), .reset(reset), .seg(tb_seg), .an(tb_an),
    .x0(x0), .x1(x1), .x2(x2), .digit_valid(valid),
    .frame_done(frame), .seg_err(serr), .an_err(aerr)
  );

  seg_scan_capture #(.TIMEOUT(16)) dut_to (
    .clocksource(clk), .reset(reset), .seg(tb_seg), .an(tb_an),
    .x0(t_x0), .x1(t_x1), .x2(t_x2), .digit_valid(t_valid),
    .frame_done(t_frame), .seg_err(t_serr), .an_err(t_aerr)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_frames = 0;
  int n_seg_err = 0;
  int n_an_err = 0;

  logic [31:0] sb_q [$];
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]  m_x [3];
  logic [2:0]  m_valid;
  logic [2:0]  m_mask;
  logic [31:0] m_last;
  logic [14:0] mon_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] snap(input logic [3:0] a0, input logic [3:0] a1,
                                       input logic [3:0] a2, input logic [2:0] v,
                                       input logic f, input logic se, input logic ae);
    return {14'b0, a2, a1, a0, v, f, se, ae};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_x[i] = 4'h0;
    m_valid = 3'b000;
    m_mask  = 3'b000;
    m_last  = 32'h0;
  endtask

  // Expected effect of one completed dwell; queues an event only if outputs visibly change
  task automatic model_eval(input logic [2:0] a, input logic [6:0] s);
    logic f, se, ae, ok;
    logic [3:0] d;
    int idx;
    logic [31:0] e;
    f = 1'b0; se = 1'b0; ae = 1'b0; ok = 1'b0; d = 4'h0; idx = -1;
    if (a == 3'b110) idx = 0;
    else if (a == 3'b101) idx = 1;
    else if (a == 3'b011) idx = 2;
    if (a == 3'b111) return;
    if (idx >= 0) begin
      for (int g = 0; g < 16; g++) if (glyph[g] == s) begin ok = 1'b1; d = 4'(g); end
      if (ok) begin
        m_x[idx] = d;
        m_valid[idx] = 1'b1;
        m_mask[idx] = 1'b1;
        if (m_mask == 3'b111) begin f = 1'b1; m_mask = 3'b000; end
      end else begin
        se = 1'b1;
      end
    end else begin
      ae = 1'b1;
    end
    e = snap(m_x[0], m_x[1], m_x[2], m_valid, f, se, ae);
    if (e != m_last) sb_q.push_back(e);
    m_last = snap(m_x[0], m_x[1], m_x[2], m_valid, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive(input logic [2:0] a, input logic [6:0] s, input int n);
    tb_an  = a;
    tb_seg = s;
    if (n >= 4) model_eval(a, s);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse or change of digits/valid is an event matched against the scoreboard
  initial begin
    logic [31:0] cur;
    mon_last = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = snap(x0, x1, x2, valid, frame, serr, aerr);
      if (reset) begin
        mon_last = cur[17:3];
      end else if (cur[2:0] != 3'b000 || cur[17:3] != mon_last) begin
        if (frame) n_frames++;
        if (serr)  n_seg_err++;
        if (aerr)  n_an_err++;
        if (sb_q.size() == 0) chk("sb_spurious", cur, {14'b0, mon_last, 3'b000});
        else                  chk("sb_event", cur, sb_q.pop_front());
        mon_last = cur[17:3];
      end
    end
  end

  initial begin
    logic [2:0] ra;
    logic [6:0] rs;
    int rn;
    logic [2:0] an_pool [7] = '{3'b110, 3'b101, 3'b011, 3'b111, 3'b100, 3'b000, 3'b010};

    // Reset with a random bus, release on blank
    reset  = 1'b1;
    tb_an  = 3'($urandom);
    tb_seg = 7'($urandom);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_outputs", snap(x0, x1, x2, valid, frame, serr, aerr), 32'h0);
    chk("rst_outputs_to", snap(t_x0, t_x1, t_x2, t_valid, t_frame, t_serr, t_aerr), 32'h0);
    reset = 1'b0;
    drive(3'b111, 7'h00, 6);
    chk("blank_no_action", snap(x0, x1, x2, valid, frame, serr, aerr), 32'h0);

    // Three-clock dwell is too short; four-clock dwell captures on its 4th edge
    drive(3'b110, 7'h4F, 3);
    drive(3'b111, 7'h00, 2);
    chk("short_dwell", 32'(valid), 32'h0);
    tb_an = 3'b110; tb_seg = 7'h4F;
    model_eval(3'b110, 7'h4F);
    repeat (3) @(negedge clk);
    chk("dwell_edge3", {24'b0, x0, 1'b0, valid}, 32'h0);
    @(negedge clk);
    chk("dwell_edge4", {24'b0, x0, 1'b0, valid}, {24'b0, 4'h3, 1'b0, 3'b001});
    repeat (2) @(negedge clk);

    // Full scan
    drive(3'b110, 7'h06, 8);
    drive(3'b101, 7'h5B, 8);
    drive(3'b011, 7'h4F, 8);
    chk("scan_values", {17'b0, x2, x1, x0, valid}, {17'b0, 4'h3, 4'h2, 4'h1, 3'b111});
    chk("scan_frames", 32'(n_frames), 32'd1);

    // Bad glyph, then illegal anodes
    drive(3'b101, 7'h00, 8);
    chk("seg_err_hold", {27'b0, x1, valid[1]}, {27'b0, 4'h2, 1'b1});
    chk("seg_err_count", 32'(n_seg_err), 32'd1);
    drive(3'b100, 7'h06, 8);
    chk("an_err_count", 32'(n_an_err), 32'd1);
    drive(3'b000, 7'h3F, 6);
    chk("an_err_count2", 32'(n_an_err), 32'd2);

    // Recapture of a digit already in the mask does not complete a frame
    drive(3'b110, 7'h6D, 6);
    drive(3'b110, 7'h7D, 6);
    drive(3'b101, 7'h77, 6);
    chk("recap_no_frame", 32'(n_frames), 32'd1);
    drive(3'b011, 7'h7C, 6);
    chk("recap_frame", 32'(n_frames), 32'd2);
    chk("recap_values", {17'b0, x2, x1, x0, valid}, {17'b0, 4'hB, 4'hA, 4'h6, 3'b111});

    // Timeout on the TIMEOUT=16 instance: digit 2 goes stale, 0/1 keep refreshing
    fork
      begin
        drive(3'b011, 7'h4F, 5);
        drive(3'b110, 7'h06, 5);
        drive(3'b101, 7'h5B, 5);
        drive(3'b110, 7'h6D, 5);
        drive(3'b101, 7'h66, 5);
        drive(3'b111, 7'h00, 1);
      end
      begin
        repeat (4) @(negedge clk);
        chk("to_capture", 32'(t_valid[2]), 32'd1);
        for (int k = 1; k <= 21; k++) begin
          @(negedge clk);
          chk($sformatf("to_valid2_k%0d", k), 32'(t_valid[2]), (k < 15) ? 32'd1 : 32'd0);
        end
      end
    join
    chk("to_others", {25'b0, t_x2, t_valid}, {25'b0, 4'h3, 3'b011});

    // Reset landing on the 3rd stable cycle restarts the dwell
    drive(3'b111, 7'h00, 2);
    tb_an = 3'b110; tb_seg = 7'h7F;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("sb_empty_at_reset", 32'(sb_q.size()), 32'd0);
    model_reset();
    model_eval(3'b110, 7'h7F);
    repeat (3) @(negedge clk);
    chk("rst_mid_edge3", {24'b0, x0, 1'b0, valid}, 32'h0);
    @(negedge clk);
    chk("rst_mid_edge4", {24'b0, x0, 1'b0, valid}, {24'b0, 4'h8, 1'b0, 3'b001});
    repeat (2) @(negedge clk);

    // Random dwells through the scoreboard
    for (int it = 0; it < 60; it++) begin
      ra = an_pool[$urandom_range(0, 6)];
      rs = ($urandom_range(0, 3) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      rn = $urandom_range(1, 7);
      if (ra == tb_an && rs == tb_seg) rs = rs ^ 7'h01;
      drive(ra, rs, rn);
    end
    drive(3'b111, 7'h00, 4);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
